// File: rtl/gray_codec_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides.
// Optional adjacency checker on Gray-mode inputs: define GRAY_CODEC_ADJCHK_EN.
module gray_codec_pipe #(
  parameter int DATA_WIDTH  = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic                  iMode,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oMode,
  output logic [DATA_WIDTH-1:0] oData
`ifdef GRAY_CODEC_ADJCHK_EN
  ,
  output logic                  oAdjErr
`endif
);

  localparam int W     = DATA_WIDTH;
  localparam int S     = PIPE_STAGES;
  localparam int CHUNK = (W + S - 1) / S;

  // Handshake: a word moves into stage k on a rising edge when the source is
  // valid and stage k is ready; stage k is ready when it is empty or stage k+1
  // is ready, and the stage after the last is ready when iReady is high.
  // Transfers upstream happen on iValid & oReady, downstream on oValid & iReady.

  logic [S-1:0] stgValid;
  logic [S-1:0] stgMode;
  logic [W-1:0] stgData [S];
  logic [S-1:0] stgReady;

  logic [S-1:0] srcValid;
  logic [S-1:0] srcMode;
  logic [W-1:0] srcData [S];
  logic [W-1:0] stgNext [S];
  logic [S-1:0] hiMask;

  // Resolve the Gray bits owned by stage k; bits above are already binary,
  // bits below are carried through as raw Gray for later stages.
  function automatic logic [W-1:0] grayStep(input logic [W-1:0] w, input int k);
    logic [W-1:0] r;
    int hi;
    int lo;
    r  = w;
    hi = W - 1 - k * CHUNK;
    lo = W - (k + 1) * CHUNK;
    for (int i = W - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) r[i] = r[i + 1] ^ r[i];
    end
    return r;
  endfunction

  always_comb begin
    srcValid[0] = iValid;
    srcMode[0]  = iMode;
    srcData[0]  = iData;
    for (int k = 1; k < S; k++) begin
      srcValid[k] = stgValid[k - 1];
      srcMode[k]  = stgMode[k - 1];
      srcData[k]  = stgData[k - 1];
    end
  end

  // Binary->Gray is done entirely in stage 0 and then only carried along.
  always_comb begin
    for (int k = 0; k < S; k++) begin
      stgNext[k] = srcData[k];
      if (!srcMode[k]) stgNext[k] = grayStep(srcData[k], k);
      else if (k == 0) stgNext[k] = srcData[k] ^ (srcData[k] >> 1);
    end
  end

  // Stage k is ready unless it and every stage after it are full and iReady is low.
  always_comb begin
    hiMask   = '0;
    stgReady = '0;
    for (int k = 0; k < S; k++) begin
      hiMask      = {S{1'b1}} << k;
      stgReady[k] = iReady || ((stgValid & hiMask) != hiMask);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stgValid <= '0;
      stgMode  <= '0;
      for (int k = 0; k < S; k++) stgData[k] <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (stgReady[k]) begin
          stgValid[k] <= srcValid[k];
          if (srcValid[k]) begin
            stgMode[k] <= srcMode[k];
            stgData[k] <= stgNext[k];
          end
        end
      end
    end
  end

  assign oReady = stgReady[0];
  assign oValid = stgValid[S - 1];
  assign oMode  = stgMode[S - 1];
  assign oData  = stgData[S - 1];

`ifdef GRAY_CODEC_ADJCHK_EN
  logic [W-1:0] lastGray;
  logic         lastGrayValid;
  logic         headErr;
  logic [S-1:0] srcErr;
  logic [S-1:0] stgErr;

  assign headErr = !iMode && lastGrayValid && ($countones(iData ^ lastGray) > 1);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      lastGray      <= '0;
      lastGrayValid <= 1'b0;
    end else if (iValid && stgReady[0] && !iMode) begin
      lastGray      <= iData;
      lastGrayValid <= 1'b1;
    end
  end

  always_comb begin
    srcErr    = '0;
    srcErr[0] = headErr;
    for (int k = 1; k < S; k++) srcErr[k] = stgErr[k - 1];
  end

  // The flag rides alongside its word so it stays aligned through stalls.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stgErr <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (stgReady[k] && srcValid[k]) stgErr[k] <= srcErr[k];
      end
    end
  end

  assign oAdjErr = stgErr[S - 1];
`endif

endmodule
